// File: rtl/opr_exec_seq_pkg.sv
// Shared widths and sequencer state encoding for the operand-execution sequencer.
// Widths track the project-wide instruction field definitions.
package opr_exec_seq_pkg;

    localparam int OPR_W      = 5;
    localparam int ALU_TYP_W  = 4;
    localparam int PRNG_TYP_W = 2;
    localparam int DLY_W      = 18;
    localparam int SEQ_ST_W   = 2;

    typedef enum logic [SEQ_ST_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETIRE = 2'd3
    } seq_st_e;

    // An ALU operation is only launched when both operand fetches are requested.
    function automatic logic alu_pair(input logic o_sel, input logic t_sel);
        return o_sel & t_sel;
    endfunction

endpackage

// File: rtl/opr_dly_counter.sv
// Delay-budget counter: load, decrement toward zero, clear; flags the final count.
// Saturates at zero so it can never wrap.
module opr_dly_counter
    import opr_exec_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [DLY_W-1:0] val,
    input  logic             dec,
    input  logic             clr,
    output logic [DLY_W-1:0] cnt,
    output logic             last
);

    logic [DLY_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_cnt <= '0;
        end else if (ld) begin
            r_cnt <= val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign cnt  = r_cnt;
    assign last = (r_cnt == DLY_W'(1));

endmodule

// File: rtl/opr_exec_seq.sv
// Execution sequencer: accepts one decoded instruction, strobes ALU/PRNG launch,
// holds for the delay budget (early exit on alu_done) and pulses retire.
module opr_exec_seq
    import opr_exec_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dec_valid,
    output logic                  dec_ready,
    input  logic [OPR_W-1:0]      opr_typ_sel,
    input  logic                  alu_o_sel,
    input  logic                  alu_t_sel,
    input  logic [ALU_TYP_W-1:0]  alu_typ_sel,
    input  logic                  prng_t_sel,
    input  logic [PRNG_TYP_W-1:0] prng_typ_sel,
    input  logic                  src_dst_delay_sel,
    input  logic [DLY_W-1:0]      src_dst_delay,
    input  logic                  alu_done,
    input  logic                  abort,
    output logic                  alu_start,
    output logic [ALU_TYP_W-1:0]  alu_typ,
    output logic                  prng_start,
    output logic [PRNG_TYP_W-1:0] prng_typ,
    output logic                  prng_seed_ld,
    output logic                  busy,
    output logic                  retire,
    output logic [OPR_W-1:0]      retire_opr,
    output logic                  alu_abort
);

    seq_st_e               r_state;
    seq_st_e               w_state_next;
    logic [OPR_W-1:0]      r_opr;
    logic                  r_alu_used;
    logic [ALU_TYP_W-1:0]  r_alu_typ;
    logic                  r_prng_seed_ld;
    logic [PRNG_TYP_W-1:0] r_prng_typ;
    logic [DLY_W-1:0]      r_dly;
    logic                  r_alu_abort;

    logic                  w_accept;
    logic                  w_in_flight;
    logic                  w_cnt_ld;
    logic                  w_cnt_dec;
    logic                  w_cnt_clr;
    logic [DLY_W-1:0]      w_cnt;
    logic                  w_cnt_last;

    assign w_accept    = dec_valid && (r_state == ST_IDLE);
    assign w_in_flight = (r_state == ST_ISSUE) || (r_state == ST_WAIT);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = src_dst_delay_sel ? ST_ISSUE : ST_RETIRE;
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (r_dly == '0) begin
                    w_state_next = ST_RETIRE;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // abort outranks both completion sources
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_cnt_last || (alu_done && r_alu_used)) begin
                    w_state_next = ST_RETIRE;
                end
            end
            ST_RETIRE: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Counter only holds a non-zero value while the sequencer sits in WAIT.
    assign w_cnt_ld  = (r_state == ST_ISSUE);
    assign w_cnt_dec = (r_state == ST_WAIT) && (w_cnt != '0);
    assign w_cnt_clr = w_in_flight && (w_state_next != ST_WAIT);

    opr_dly_counter u_dly_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (w_cnt_ld),
        .val   (r_dly),
        .dec   (w_cnt_dec),
        .clr   (w_cnt_clr),
        .cnt   (w_cnt),
        .last  (w_cnt_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_opr          <= '0;
            r_alu_used     <= 1'b0;
            r_alu_typ      <= '0;
            r_prng_seed_ld <= 1'b0;
            r_prng_typ     <= '0;
            r_dly          <= '0;
            r_alu_abort    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_alu_abort <= abort && w_in_flight && r_alu_used;
            if (w_accept) begin
                r_opr          <= opr_typ_sel;
                r_alu_used     <= alu_pair(alu_o_sel, alu_t_sel);
                r_alu_typ      <= alu_typ_sel;
                r_prng_seed_ld <= prng_t_sel;
                r_prng_typ     <= prng_typ_sel;
                r_dly          <= src_dst_delay;
            end else if (w_state_next == ST_IDLE) begin
                r_opr          <= '0;
                r_alu_used     <= 1'b0;
                r_alu_typ      <= '0;
                r_prng_seed_ld <= 1'b0;
                r_prng_typ     <= '0;
                r_dly          <= '0;
            end
        end
    end

    assign dec_ready    = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign alu_start    = (r_state == ST_ISSUE) && r_alu_used;
    assign prng_start   = (r_state == ST_ISSUE) && (r_prng_typ != '0);
    assign alu_typ      = r_alu_typ;
    assign prng_typ     = r_prng_typ;
    assign prng_seed_ld = r_prng_seed_ld;
    assign retire       = (r_state == ST_RETIRE);
    assign retire_opr   = r_opr;
    assign alu_abort    = r_alu_abort;

endmodule
